hash_table_requester: RTL and testbench
=======================================

HASH_TABLE_REQUESTER -- requirements
Module: hash_table_requester

Interface
REQ-001 Parameter KEY_WIDTH, default 2, is the key width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, is the payload width in bits.
REQ-003 Parameter RESP_LATENCY, default 3, is the number of cycles from a table op being driven to its status and read data being valid.
REQ-004 Parameter RSP_FIFO_DEPTH, default 4, is the number of response FIFO entries; it is a power of two and at least 2.
REQ-005 clk  in  1  single clock for the block; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid_i / req_ready_o  in/out  1/1  request handshake; transfer when both are high.
REQ-008 req_op_i  in  2  requested op: 01 read, 10 write, 11 delete; 00 is ignored and never accepted.
REQ-009 req_key_i / req_data_i  in  KEY_WIDTH / DATA_WIDTH  request key and write payload.
REQ-010 tbl_op_o  out  2  registered op to the hash table (delete_write_read encoding above, 00 = NOP).
REQ-011 tbl_key_o / tbl_data_o  out  KEY_WIDTH / DATA_WIDTH  registered key and data to the table.
REQ-012 tbl_read_data_i  in  DATA_WIDTH  table read data.
REQ-013 tbl_no_element_found_i / tbl_no_write_space_i / tbl_no_deletion_target_i  in  1 each  table status flags.
REQ-014 rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-015 rsp_op_o / rsp_key_o / rsp_data_o  out  2 / KEY_WIDTH / DATA_WIDTH  completed op, its key, and read data.
REQ-016 rsp_status_o  out  2  00 OK, 01 NOT_FOUND, 10 NO_SPACE, 11 NO_TARGET.
REQ-017 busy_o  out  1  high while any op is in flight or any response is queued.

Function
REQ-018 An accepted request drives tbl_op_o/key/data for exactly the next cycle; in every other cycle tbl_op_o is 00 and tbl_key_o/tbl_data_o are 0.
REQ-019 At most one request is accepted per cycle.
REQ-020 A tag shift register of RESP_LATENCY stages (valid, op, key) tracks every issued op; when the tag emerges, table flags and read data are sampled in that cycle.
REQ-021 Status mapping:
- read: NOT_FOUND if tbl_no_element_found_i, else OK.
- write: NO_SPACE if tbl_no_write_space_i, else OK.
- delete: NO_TARGET if tbl_no_deletion_target_i, else OK.
- Flags not belonging to the op are ignored.
REQ-022 rsp_data_o carries tbl_read_data_i for an OK read and 0 otherwise.
REQ-023 Each sampled result is pushed into the response FIFO; responses leave in issue order.
REQ-024 Credit rule: req_ready_o is high only when (in-flight count + FIFO occupancy) < RSP_FIFO_DEPTH, so the FIFO never overflows. A push and a pop in the same cycle leave occupancy unchanged.
REQ-025 Hazard rule: req_ready_o is low while any in-flight tag has a key equal to req_key_i and either that tag or the incoming op is a write or delete. Read-after-read to the same key is allowed back-to-back.
REQ-026 req_ready_o is combinational from state and req_key_i/req_op_i only; it never depends on req_valid_i.
REQ-027 rsp_valid_o is high whenever the FIFO is non-empty. Response fields are held stable until rsp_ready_i is high.
REQ-028 Full FIFO with rsp_ready_i low: no loss and no reordering; issue resumes as credits return.
REQ-029 Full-throughput latency: a request accepted in cycle N yields rsp_valid_o in cycle N+1+RESP_LATENCY+1 when the FIFO was empty.

Reset
REQ-030 On reset:
- req_ready_o is 0 in the reset cycle.
- tbl_op_o = 00; tbl_key_o = tbl_data_o = 0.
- All tags are invalidated; FIFO pointers and count are cleared.
- rsp_valid_o = 0, rsp_* = 0, busy_o = 0.
REQ-031 Reset asserted mid-operation discards all in-flight and queued ops; no response is produced for them.

Structure
REQ-032 A shared package holds the op encoding constants (NOP, READ, WRITE, DELETE) and the status encoding as a typedef enum.
REQ-033 The response FIFO is one sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-034 Write key 2 data 0xDEADBEEF, then read key 2 with the table returning 0xDEADBEEF -> responses (WRITE,2,0,OK) then (READ,2,0xDEADBEEF,OK). The read issue is delayed until the write tag retires.
REQ-035 Back-to-back reads of keys 0,1,2,3, rsp_ready_i=1 -> one accept per cycle; four OK responses in order; first response at cycle N+RESP_LATENCY+2.
REQ-036 Read of key 1 with tbl_no_element_found_i=1 -> status NOT_FOUND, data 0. Delete with tbl_no_deletion_target_i=1 -> NO_TARGET.
REQ-037 rsp_ready_i=0 and 6 read requests offered (RSP_FIFO_DEPTH=4) -> exactly 4 accepted and req_ready_o stays low. Raising rsp_ready_i drains all 6 in order.
REQ-038 Reset asserted one cycle after issuing 2 ops -> no responses, busy_o=0, tbl_op_o=00 the next cycle.
REQ-039 Write key 3 immediately followed by delete key 3 -> delete stalled RESP_LATENCY+1 cycles; both responses OK in order.

Source files
------------

// File: rtl/hash_table_requester_pkg.sv
// Shared definitions for the hash table requester.
// Holds the table op encoding, the response status encoding and the
// helper that turns the per-op table flags into a response status.
package hash_table_requester_pkg;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_WRITE  = 2'b10;
   localparam logic [1:0] OP_DELETE = 2'b11;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_NOT_FOUND = 2'b01,
      ST_NO_SPACE  = 2'b10,
      ST_NO_TARGET = 2'b11
   } rsp_status_e;

   // Only the flag that belongs to the op is looked at; the others are
   // don't-care for that op.
   function automatic rsp_status_e map_status(input logic [1:0] op,
                                              input logic       no_element_found,
                                              input logic       no_write_space,
                                              input logic       no_deletion_target);
      rsp_status_e st;
      st = ST_OK;
      case (op)
         OP_READ:   if (no_element_found)   st = ST_NOT_FOUND;
         OP_WRITE:  if (no_write_space)     st = ST_NO_SPACE;
         OP_DELETE: if (no_deletion_target) st = ST_NO_TARGET;
         default:   st = ST_OK;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (clears pointers/count)
//   push_i, din_i     - write strobe and data; ignored when full
//   pop_i             - read strobe; ignored when empty
//   dout_o            - head entry (valid while empty_o is low)
//   empty_o, full_o   - status
//   count_o           - current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/hash_table_requester.sv
// Issues read/write/delete ops to a fixed-latency hash table and returns
// one response per op, in issue order, through a small response FIFO.
//
// Handshakes (both sides): a beat transfers on a rising edge where valid
// and ready are both high. A source holds its payload stable while valid
// is high and ready is low. req_ready_o depends only on internal state,
// reset, req_key_i and req_op_i, never on req_valid_i.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid_i/req_ready_o    - request handshake
//   req_op_i/key_i/data_i      - op (01 rd, 10 wr, 11 del; 00 never accepted), key, payload
//   tbl_op_o/key_o/data_o      - registered op to the table, zero when idle
//   tbl_read_data_i, tbl_no_*  - table results, valid RESP_LATENCY cycles after the op
//   rsp_valid_o/rsp_ready_i    - response handshake
//   rsp_op_o/key_o/data_o      - completed op, its key, read data (OK reads only)
//   rsp_status_o               - 00 OK, 01 NOT_FOUND, 10 NO_SPACE, 11 NO_TARGET
//   busy_o                     - any op in flight or response queued
module hash_table_requester
   import hash_table_requester_pkg::*;
#(
   parameter int KEY_WIDTH      = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int RESP_LATENCY   = 3,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [KEY_WIDTH-1:0]  req_key_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic [1:0]            tbl_op_o,
   output logic [KEY_WIDTH-1:0]  tbl_key_o,
   output logic [DATA_WIDTH-1:0] tbl_data_o,
   input  logic [DATA_WIDTH-1:0] tbl_read_data_i,
   input  logic                  tbl_no_element_found_i,
   input  logic                  tbl_no_write_space_i,
   input  logic                  tbl_no_deletion_target_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [1:0]            rsp_op_o,
   output logic [KEY_WIDTH-1:0]  rsp_key_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic [1:0]            rsp_status_o,
   output logic                  busy_o
);

   localparam int ENTRY_W = 2 + KEY_WIDTH + 2 + DATA_WIDTH;
   localparam int CNT_W   = $clog2(RSP_FIFO_DEPTH) + 1;
   localparam int LAST    = RESP_LATENCY - 1;

   // Table launch register: holds an accepted op for exactly one cycle.
   logic [1:0]            tbl_op_q, tbl_op_d;
   logic [KEY_WIDTH-1:0]  tbl_key_q, tbl_key_d;
   logic [DATA_WIDTH-1:0] tbl_data_q, tbl_data_d;

   // Tag pipeline behind the launch register; the last stage lines up with
   // the cycle in which the table result for that op is valid.
   logic                  tag_valid_q [RESP_LATENCY];
   logic                  tag_valid_d [RESP_LATENCY];
   logic [1:0]            tag_op_q    [RESP_LATENCY];
   logic [1:0]            tag_op_d    [RESP_LATENCY];
   logic [KEY_WIDTH-1:0]  tag_key_q   [RESP_LATENCY];
   logic [KEY_WIDTH-1:0]  tag_key_d   [RESP_LATENCY];

   logic [15:0]           in_flight;
   logic                  hazard;
   logic                  credit_ok;
   logic                  accept;

   logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CNT_W-1:0]      fifo_count;
   logic [ENTRY_W-1:0]    fifo_din, fifo_dout;
   rsp_status_e           done_status;
   logic [DATA_WIDTH-1:0] done_data;

   // Two ops conflict on the same key unless both are reads.
   function automatic logic conflicts(input logic [1:0] op_a,
                                      input logic [1:0] op_b);
      return (op_a != OP_READ) || (op_b != OP_READ);
   endfunction

   // Admission: count everything that will eventually occupy a FIFO slot
   // (launch register, tag stages, FIFO entries) and check key hazards.
   always_comb begin
      in_flight = '0;
      hazard    = 1'b0;
      if (tbl_op_q != OP_NOP) begin
         in_flight = in_flight + 16'd1;
         if ((tbl_key_q == req_key_i) && conflicts(tbl_op_q, req_op_i)) begin
            hazard = 1'b1;
         end
      end
      for (int i = 0; i < RESP_LATENCY; i++) begin
         if (tag_valid_q[i]) begin
            in_flight = in_flight + 16'd1;
            if ((tag_key_q[i] == req_key_i) && conflicts(tag_op_q[i], req_op_i)) begin
               hazard = 1'b1;
            end
         end
      end
      credit_ok   = (in_flight + 16'(fifo_count)) < 16'(RSP_FIFO_DEPTH);
      req_ready_o = !reset && (req_op_i != OP_NOP) && !hazard && credit_ok;
      accept      = req_valid_i && req_ready_o;
   end

   always_comb begin
      tbl_op_d   = OP_NOP;
      tbl_key_d  = '0;
      tbl_data_d = '0;
      if (accept) begin
         tbl_op_d   = req_op_i;
         tbl_key_d  = req_key_i;
         tbl_data_d = req_data_i;
      end
      tag_valid_d[0] = (tbl_op_q != OP_NOP);
      tag_op_d[0]    = tbl_op_q;
      tag_key_d[0]   = tbl_key_q;
      for (int i = 1; i < RESP_LATENCY; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_op_d[i]    = tag_op_q[i-1];
         tag_key_d[i]   = tag_key_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tbl_op_q   <= OP_NOP;
         tbl_key_q  <= '0;
         tbl_data_q <= '0;
         for (int i = 0; i < RESP_LATENCY; i++) begin
            tag_valid_q[i] <= 1'b0;
            tag_op_q[i]    <= OP_NOP;
            tag_key_q[i]   <= '0;
         end
      end else begin
         tbl_op_q   <= tbl_op_d;
         tbl_key_q  <= tbl_key_d;
         tbl_data_q <= tbl_data_d;
         for (int i = 0; i < RESP_LATENCY; i++) begin
            tag_valid_q[i] <= tag_valid_d[i];
            tag_op_q[i]    <= tag_op_d[i];
            tag_key_q[i]   <= tag_key_d[i];
         end
      end
   end

   // Result capture for the tag in the last stage.
   always_comb begin
      done_status = map_status(tag_op_q[LAST], tbl_no_element_found_i,
                               tbl_no_write_space_i, tbl_no_deletion_target_i);
      done_data   = '0;
      if ((tag_op_q[LAST] == OP_READ) && (done_status == ST_OK)) begin
         done_data = tbl_read_data_i;
      end
      fifo_push = tag_valid_q[LAST] && !fifo_full;
      fifo_din  = {tag_op_q[LAST], tag_key_q[LAST], done_status, done_data};
      fifo_pop  = rsp_ready_i && !fifo_empty;
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RSP_FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   assign tbl_op_o    = tbl_op_q;
   assign tbl_key_o   = tbl_key_q;
   assign tbl_data_o  = tbl_data_q;

   // Fields are forced to zero while empty so stale storage never shows.
   assign rsp_valid_o = !fifo_empty;
   assign {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o} =
      rsp_valid_o ? fifo_dout : '0;

   assign busy_o = (in_flight != 16'd0) || !fifo_empty;

endmodule

// File: tb/tb_hash_table_requester.sv
module tb_hash_table_requester;

  localparam int KW  = 2;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int EW  = 2 + KW + 2 + DW;

  localparam logic [1:0] O_R = 2'b01, O_W = 2'b10, O_D = 2'b11;
  localparam logic [1:0] S_OK = 2'b00, S_NF = 2'b01, S_NS = 2'b10, S_NT = 2'b11;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = 2'b00;
  logic [KW-1:0] req_key_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic [1:0]    tbl_op_o;
  logic [KW-1:0] tbl_key_o;
  logic [DW-1:0] tbl_data_o;
  logic [DW-1:0] tbl_read_data_i = JUNK;
  logic          tbl_no_element_found_i = 1'b1;
  logic          tbl_no_write_space_i = 1'b1;
  logic          tbl_no_deletion_target_i = 1'b1;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [1:0]    rsp_op_o;
  logic [KW-1:0] rsp_key_o;
  logic [DW-1:0] rsp_data_o;
  logic [1:0]    rsp_status_o;
  logic          busy_o;

  hash_table_requester #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .RESP_LATENCY(LAT), .RSP_FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .tbl_op_o(tbl_op_o), .tbl_key_o(tbl_key_o), .tbl_data_o(tbl_data_o),
    .tbl_read_data_i(tbl_read_data_i),
    .tbl_no_element_found_i(tbl_no_element_found_i),
    .tbl_no_write_space_i(tbl_no_write_space_i),
    .tbl_no_deletion_target_i(tbl_no_deletion_target_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_op_o(rsp_op_o), .rsp_key_o(rsp_key_o), .rsp_data_o(rsp_data_o),
    .rsp_status_o(rsp_status_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_rsp_cyc = -1;

  logic [EW-1:0] exp_q[$];

  // ---------------- table model ----------------
  // Results scheduled LAT cycles after the op appears on tbl_op_o.
  typedef struct {
    logic nf;
    logic ns;
    logic nt;
    logic [DW-1:0] rd;
  } slot_t;

  slot_t         ring [8];
  logic [DW-1:0] tmem [4];
  logic          tpres [4];
  logic          force_full = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    tbl_no_element_found_i   = ring[cyc % 8].nf;
    tbl_no_write_space_i     = ring[cyc % 8].ns;
    tbl_no_deletion_target_i = ring[cyc % 8].nt;
    tbl_read_data_i          = ring[cyc % 8].rd;
    ring[cyc % 8] = '{1'b1, 1'b1, 1'b1, JUNK};
  end

  logic          held = 1'b0;
  logic [EW-1:0] held_val;

  always @(negedge clk) begin
    slot_t s;
    if (!reset) begin
      if (tbl_op_o == 2'b00) begin
        tests++;
        if (tbl_key_o != '0 || tbl_data_o != '0) begin
          fails++;
          $display("FAIL tbl_idle_zero: key=%0h data=%0h, required 0/0", tbl_key_o, tbl_data_o);
        end
      end else begin
        s = '{1'b1, 1'b1, 1'b1, JUNK};
        case (tbl_op_o)
          O_R: begin
            s.nf = !tpres[tbl_key_o];
            if (tpres[tbl_key_o]) s.rd = tmem[tbl_key_o];
          end
          O_W: begin
            s.ns = force_full;
            if (!force_full) begin
              tmem[tbl_key_o]  = tbl_data_o;
              tpres[tbl_key_o] = 1'b1;
            end
          end
          default: begin
            s.nt = !tpres[tbl_key_o];
            tpres[tbl_key_o] = 1'b0;
          end
        endcase
        ring[(cyc + LAT) % 8] = s;
      end
    end
    // ---------------- scoreboard ----------------
    if (rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc;
    if (held) begin
      tests++;
      if ({rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o} !== held_val || !rsp_valid_o) begin
        fails++;
        $display("FAIL rsp_hold: got %h, required %h held", {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o}, held_val);
      end
    end
    held = rsp_valid_o && !rsp_ready_i && !reset;
    held_val = {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o};
    if (rsp_valid_o && rsp_ready_i && !reset) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got %h, required no response", {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o});
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o} !== e) begin
          fails++;
          $display("FAIL rsp: got %h, required %h", {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [1:0] key,
                      input logic [31:0] data, output int acc);
    acc = -1;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_key_i   = key;
    req_data_i  = data;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = cyc;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        return;
      end
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    req_op_i    = 2'b00;
    tests++;
    fails++;
    $display("FAIL send_timeout: op=%0d key=%0d not accepted in 40 cycles", op, key);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) done = 1'b1;
    end
    @(posedge clk); #1;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] op, input logic [1:0] key,
                                       input logic [1:0] st, input logic [31:0] d);
    return {op, key, st, d};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  key;
    logic [31:0] data;
    logic        full;
    logic [1:0]  exp_st;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  // ---------------- test sequence ----------------
  initial begin
    int acc, acc2, n_acc;
    int accs [6];
    logic [1:0] keys6 [6];

    for (int i = 0; i < 8; i++) ring[i] = '{1'b1, 1'b1, 1'b1, JUNK};
    for (int i = 0; i < 4; i++) begin tmem[i] = '0; tpres[i] = 1'b0; end

    vecs[0]  = '{O_R, 2'd1, 32'h0,         1'b0, S_NF, 32'h0};
    vecs[1]  = '{O_W, 2'd1, 32'h1111_2222, 1'b0, S_OK, 32'h0};
    vecs[2]  = '{O_R, 2'd1, 32'h0,         1'b0, S_OK, 32'h1111_2222};
    vecs[3]  = '{O_D, 2'd1, 32'h0,         1'b0, S_OK, 32'h0};
    vecs[4]  = '{O_D, 2'd1, 32'h0,         1'b0, S_NT, 32'h0};
    vecs[5]  = '{O_R, 2'd1, 32'h0,         1'b0, S_NF, 32'h0};
    vecs[6]  = '{O_W, 2'd0, 32'hA5A5_A5A5, 1'b1, S_NS, 32'h0};
    vecs[7]  = '{O_R, 2'd0, 32'h0,         1'b0, S_NF, 32'h0};
    vecs[8]  = '{O_W, 2'd3, 32'hFFFF_FFFF, 1'b0, S_OK, 32'h0};
    vecs[9]  = '{O_R, 2'd3, 32'h0,         1'b0, S_OK, 32'hFFFF_FFFF};
    vecs[10] = '{O_D, 2'd3, 32'h0,         1'b0, S_OK, 32'h0};
    vecs[11] = '{O_R, 2'd2, 32'h0,         1'b0, S_NF, 32'h0};

    // Reset state, with a read offered during reset.
    req_valid_i = 1'b1; req_op_i = O_R; req_key_i = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", req_ready_o, 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    check("reset_tbl_op", tbl_op_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_rsp_fields", {rsp_op_o, rsp_key_o, rsp_status_o, rsp_data_o}, 0);
    check("reset_busy", busy_o, 0);
    @(posedge clk); #1;

    // Table-driven single ops; table state carries from vector to vector.
    for (int v = 0; v < 12; v++) begin
      force_full = vecs[v].full;
      send(vecs[v].op, vecs[v].key, vecs[v].data, acc);
      if (acc >= 0) exp_q.push_back(mk(vecs[v].op, vecs[v].key, vecs[v].exp_st, vecs[v].exp_data));
      wait_drain($sformatf("vec%0d", v));
      force_full = 1'b0;
    end

    // Write then read of the same key: read waits for the write to retire.
    send(O_W, 2'd2, 32'hDEAD_BEEF, acc);
    exp_q.push_back(mk(O_W, 2'd2, S_OK, 32'h0));
    send(O_R, 2'd2, 32'h0, acc2);
    exp_q.push_back(mk(O_R, 2'd2, S_OK, 32'hDEAD_BEEF));
    check("raw_stall", acc2 - acc, LAT + 2);
    wait_drain("raw");

    // Back-to-back reads of distinct keys, then read-after-read same key.
    for (int i = 0; i < 4; i++) begin tmem[i] = 32'h1000_0000 + i; tpres[i] = 1'b1; end
    first_rsp_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      send(O_R, 2'(i), 32'h0, accs[i]);
      exp_q.push_back(mk(O_R, 2'(i), S_OK, 32'h1000_0000 + i));
    end
    for (int i = 1; i < 4; i++) check("b2b_accept", accs[i] - accs[0], i);
    wait_drain("b2b");
    check("b2b_first_rsp", first_rsp_cyc, accs[0] + LAT + 2);
    send(O_R, 2'd2, 32'h0, acc);
    exp_q.push_back(mk(O_R, 2'd2, S_OK, 32'h1000_0002));
    send(O_R, 2'd2, 32'h0, acc2);
    exp_q.push_back(mk(O_R, 2'd2, S_OK, 32'h1000_0002));
    check("rar_no_stall", acc2 - acc, 1);
    wait_drain("rar");

    // Write then delete of the same key.
    send(O_W, 2'd3, 32'h3333_3333, acc);
    exp_q.push_back(mk(O_W, 2'd3, S_OK, 32'h0));
    send(O_D, 2'd3, 32'h0, acc2);
    exp_q.push_back(mk(O_D, 2'd3, S_OK, 32'h0));
    check("waw_stall", acc2 - acc, LAT + 2);
    wait_drain("wd");

    // Credit limit with a stalled consumer.
    for (int i = 0; i < 4; i++) begin tmem[i] = 32'h2000_0000 + i; tpres[i] = 1'b1; end
    keys6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rsp_ready_i = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 14; t++) begin
      req_valid_i = 1'b1;
      req_op_i    = O_R;
      req_key_i   = keys6[n_acc < 6 ? n_acc : 5];
      @(negedge clk);
      if (req_ready_o && n_acc < 6) begin
        exp_q.push_back(mk(O_R, keys6[n_acc], S_OK, 32'h2000_0000 + 32'(keys6[n_acc])));
        n_acc++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("credit_accepts", n_acc, DEP);
    check("credit_ready_low", req_ready_o, 0);
    check("credit_busy", busy_o, 1);
    check("credit_rsp_valid", rsp_valid_o, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_op_i = 2'b00;
    rsp_ready_i = 1'b1;
    for (int i = n_acc; i < 6; i++) begin
      send(O_R, keys6[i], 32'h0, acc);
      if (acc >= 0) exp_q.push_back(mk(O_R, keys6[i], S_OK, 32'h2000_0000 + 32'(keys6[i])));
    end
    wait_drain("credit");

    // Reset with two ops in flight: nothing may come out.
    send(O_R, 2'd0, 32'h0, acc);
    send(O_W, 2'd1, 32'h5555_5555, acc2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_tbl_op", tbl_op_o, 0);
    check("midreset_busy", busy_o, 0);
    check("midreset_rsp_valid", rsp_valid_o, 0);
    n_acc = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp_valid_o || busy_o) n_acc++;
    end
    check("midreset_quiet", n_acc, 0);
    check("final_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
